// File: rtl/div_if.sv
// Handshake and data bundle between the EX stage and the sequential divider.
// The master side issues a divide request and the slave side returns the result.
interface div_if #(
    parameter int WIDTH = 32
);
    logic                   start_i;
    logic                   annul_i;
    logic                   signed_div_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;

    modport master (
        output start_i,
        output annul_i,
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  start_i,
        input  annul_i,
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned.
// The result is {remainder, quotient} and is held while EX keeps start_i high.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst,
    div_if.slave    bus
);

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] negate_f(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] cond_negate_f(input logic [WIDTH-1:0] v,
                                                       input logic            neg);
        return neg ? negate_f(v) : v;
    endfunction

    state_t                 state_r;
    logic [5:0]             cnt_r;
    logic [2*WIDTH-1:0]     acc_r;
    logic [WIDTH-1:0]       divisor_r;
    logic                   signed_r;
    logic                   dvd_neg_r;
    logic                   dvs_neg_r;
    logic [2*WIDTH-1:0]     result_r;
    logic                   ready_r;

    logic                   go_s;
    logic                   stop_s;
    logic                   divisor_zero_s;
    logic                   dvd_neg_s;
    logic                   dvs_neg_s;
    logic [WIDTH-1:0]       dvd_mag_s;
    logic [WIDTH-1:0]       dvs_mag_s;
    logic [2*WIDTH:0]       shifted_s;
    logic [WIDTH:0]         trial_s;
    logic [2*WIDTH-1:0]     acc_next_s;
    logic [WIDTH-1:0]       quo_fix_s;
    logic [WIDTH-1:0]       rem_fix_s;

    assign go_s           = bus.start_i & ~bus.annul_i;
    assign stop_s         = bus.annul_i | ~bus.start_i;
    assign divisor_zero_s = (bus.opdata2_i == {WIDTH{1'b0}});

    // Signed operands enter the datapath as magnitudes; signs are fixed up at the end.
    assign dvd_neg_s = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    assign dvs_neg_s = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    assign dvd_mag_s = cond_negate_f(bus.opdata1_i, dvd_neg_s);
    assign dvs_mag_s = cond_negate_f(bus.opdata2_i, dvs_neg_s);

    // One restoring step over the 65-bit {partial remainder, quotient} window.
    assign shifted_s  = {acc_r, 1'b0};
    assign trial_s    = shifted_s[2*WIDTH:WIDTH] - {1'b0, divisor_r};
    assign acc_next_s = trial_s[WIDTH] ? shifted_s[2*WIDTH-1:0]
                                       : {trial_s[WIDTH-1:0], shifted_s[WIDTH-1:1], 1'b1};

    // Quotient sign follows the operand-sign XOR, remainder follows the dividend.
    assign quo_fix_s = cond_negate_f(acc_next_s[WIDTH-1:0],
                                     signed_r & (dvd_neg_r ^ dvs_neg_r));
    assign rem_fix_s = cond_negate_f(acc_next_s[2*WIDTH-1:WIDTH],
                                     signed_r & dvd_neg_r);

    assign bus.result_o = result_r;
    assign bus.ready_o  = ready_r;

    // Control FSM, step counter, datapath register and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= FREE;
            cnt_r     <= 6'd0;
            acc_r     <= {(2*WIDTH){1'b0}};
            divisor_r <= {WIDTH{1'b0}};
            signed_r  <= 1'b0;
            dvd_neg_r <= 1'b0;
            dvs_neg_r <= 1'b0;
            result_r  <= {(2*WIDTH){1'b0}};
            ready_r   <= 1'b0;
        end else begin
            case (state_r)
                FREE: begin
                    ready_r  <= 1'b0;
                    result_r <= {(2*WIDTH){1'b0}};
                    if (go_s) begin
                        if (divisor_zero_s) begin
                            state_r <= BYZERO;
                        end else begin
                            state_r   <= ON;
                            cnt_r     <= 6'd0;
                            acc_r     <= {{WIDTH{1'b0}}, dvd_mag_s};
                            divisor_r <= dvs_mag_s;
                            signed_r  <= bus.signed_div_i;
                            dvd_neg_r <= bus.opdata1_i[WIDTH-1];
                            dvs_neg_r <= bus.opdata2_i[WIDTH-1];
                        end
                    end else begin
                        state_r <= FREE;
                    end
                end
                BYZERO: begin
                    result_r <= {(2*WIDTH){1'b0}};
                    if (stop_s) begin
                        state_r <= FREE;
                        ready_r <= 1'b0;
                    end else begin
                        state_r <= END;
                        ready_r <= 1'b1;
                    end
                end
                ON: begin
                    if (stop_s) begin
                        state_r  <= FREE;
                        ready_r  <= 1'b0;
                        result_r <= {(2*WIDTH){1'b0}};
                    end else begin
                        acc_r <= acc_next_s;
                        cnt_r <= cnt_r + 6'd1;
                        if (cnt_r == LAST_STEP) begin
                            state_r  <= END;
                            ready_r  <= 1'b1;
                            result_r <= {rem_fix_s, quo_fix_s};
                        end else begin
                            state_r  <= ON;
                            ready_r  <= 1'b0;
                            result_r <= {(2*WIDTH){1'b0}};
                        end
                    end
                end
                END: begin
                    if (stop_s) begin
                        state_r  <= FREE;
                        ready_r  <= 1'b0;
                        result_r <= {(2*WIDTH){1'b0}};
                    end else begin
                        state_r <= END;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= FREE;
                    ready_r  <= 1'b0;
                    result_r <= {(2*WIDTH){1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: an arithmetic reference model is compared every
// cycle, and hand-computed results and latencies pin the model itself.
module tb_div_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_if #(.WIDTH(32)) bus ();
    div_seq #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    typedef enum {M_IDLE, M_BUSY, M_DONE} phase_t;
    phase_t      m_ph = M_IDLE;
    logic        m_ready = 1'b0;
    logic [63:0] m_result = 64'd0;
    logic [63:0] m_val = 64'd0;
    int          m_left = 0;

    // Reference arithmetic: truncating division, remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Transaction-level model: accept from idle, count down the latency, hold the answer.
    always @(posedge clk) begin
        if (rst) begin
            m_ph     <= M_IDLE;
            m_ready  <= 1'b0;
            m_result <= 64'd0;
        end else begin
            case (m_ph)
                M_IDLE: if (bus.start_i && !bus.annul_i) begin
                    m_val  <= ref_div(bus.signed_div_i, bus.opdata1_i, bus.opdata2_i);
                    m_left <= (bus.opdata2_i == 32'd0) ? 1 : 32;
                    m_ph   <= M_BUSY;
                end
                M_BUSY: if (bus.annul_i || !bus.start_i) begin
                    m_ph <= M_IDLE;
                end else if (m_left == 1) begin
                    m_ph     <= M_DONE;
                    m_ready  <= 1'b1;
                    m_result <= m_val;
                end else begin
                    m_left <= m_left - 1;
                end
                M_DONE: if (bus.annul_i || !bus.start_i) begin
                    m_ph     <= M_IDLE;
                    m_ready  <= 1'b0;
                    m_result <= 64'd0;
                end
                default: m_ph <= M_IDLE;
            endcase
        end
    end

    task automatic cmp_model();
        n_chk++;
        if (bus.ready_o !== m_ready || bus.result_o !== m_result) begin
            n_fail++;
            $display("FAIL model t=%0t: got ready=%b result=%h, required ready=%b result=%h",
                     $time, bus.ready_o, bus.result_o, m_ready, m_result);
        end
    endtask

    task automatic lit(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Compare against the model on the falling edge, then step past the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (chk_en) cmp_model();
        @(posedge clk);
        #1;
    endtask

    // Raise start and count edges until ready; lat 0 is the edge that samples start.
    task automatic wait_ready(output int lat);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 100) begin
            tick();
            n++;
            if (n == 3) begin
                bus.opdata1_i    = ~bus.opdata1_i;
                bus.opdata2_i    = bus.opdata2_i ^ 32'h0000_0005;
                bus.signed_div_i = ~bus.signed_div_i;
            end
            if (bus.ready_o) seen = 1'b1;
        end
        lat = n - 1;
    endtask

    task automatic do_div(input string name, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp,
                          input int exp_lat, input int hold);
        int lat;
        bus.signed_div_i = sg;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        wait_ready(lat);
        lit({name, "_latency"}, 64'(lat), 64'(exp_lat));
        lit({name, "_result"}, bus.result_o, exp);
        repeat (hold) tick();
        lit({name, "_held"}, {bus.result_o[62:0], bus.ready_o}, {exp[62:0], 1'b1});
        bus.start_i = 1'b0;
        tick();
        lit({name, "_drop"}, {bus.result_o[62:0], bus.ready_o}, 64'd0);
    endtask

    typedef struct {
        string       name;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[10];
    int   lat;

    initial begin
        vecs[0] = '{"u100_7",    1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 32, 2};
        vecs[1] = '{"s_m7_2",    1'b1, 32'hFFFFFFF9,  32'd2,         64'hFFFFFFFF_FFFFFFFD, 32, 0};
        vecs[2] = '{"u5_0",      1'b0, 32'd5,         32'd0,         64'h00000000_00000000, 1,  1};
        vecs[3] = '{"s_min_m1",  1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 32, 1};
        vecs[4] = '{"s7_m2",     1'b1, 32'd7,         32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 32, 0};
        vecs[5] = '{"s_m8_m3",   1'b1, 32'hFFFFFFF8,  32'hFFFFFFFD,  64'hFFFFFFFE_00000002, 32, 0};
        vecs[6] = '{"u_min_max", 1'b0, 32'h80000000,  32'hFFFFFFFF,  64'h80000000_00000000, 32, 0};
        vecs[7] = '{"u_max_1",   1'b0, 32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF, 32, 0};
        vecs[8] = '{"s5_0",      1'b1, 32'd5,         32'd0,         64'h00000000_00000000, 1,  0};
        vecs[9] = '{"u0_5",      1'b0, 32'd0,         32'd5,         64'h00000000_00000000, 32, 0};

        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd0;
        bus.opdata2_i    = 32'd0;

        // Reset with a request already pending, which reset must override.
        bus.start_i = 1'b1;
        bus.opdata2_i = 32'd3;
        tick();
        tick();
        chk_en = 1'b1;
        lit("reset_state", {bus.result_o[62:0], bus.ready_o}, 64'd0);
        bus.start_i = 1'b0;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            do_div(vecs[i].name, vecs[i].sg, vecs[i].a, vecs[i].b,
                   vecs[i].exp, vecs[i].lat, vecs[i].hold);
        end

        // Flush at step 10 of a running divide: no result may appear.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        repeat (11) tick();
        bus.annul_i = 1'b1;
        tick();
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        repeat (40) tick();
        lit("annul_on_ready", {63'd0, bus.ready_o}, 64'd0);
        do_div("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 32, 0);

        // Annul with start in FREE keeps the block idle.
        bus.opdata1_i = 32'd20;
        bus.opdata2_i = 32'd4;
        bus.start_i   = 1'b1;
        bus.annul_i   = 1'b1;
        repeat (5) tick();
        lit("annul_free", {bus.result_o[62:0], bus.ready_o}, 64'd0);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        tick();

        // Annul in BYZERO.
        bus.opdata2_i = 32'd0;
        bus.start_i   = 1'b1;
        tick();
        bus.annul_i = 1'b1;
        tick();
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        repeat (3) tick();
        lit("annul_byzero", {63'd0, bus.ready_o}, 64'd0);

        // Annul in END clears the result.
        bus.opdata1_i = 32'd20;
        bus.opdata2_i = 32'd4;
        bus.start_i   = 1'b1;
        wait_ready(lat);
        lit("pre_annul_end", bus.result_o, 64'h00000000_00000005);
        bus.annul_i = 1'b1;
        tick();
        lit("annul_end", {bus.result_o[62:0], bus.ready_o}, 64'd0);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        repeat (3) tick();

        // Reset at step 20, then a request accepted on the first free cycle.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd50;
        bus.opdata2_i    = 32'd5;
        bus.start_i      = 1'b1;
        repeat (21) tick();
        rst = 1'b1;
        tick();
        lit("rst_mid_on", {bus.result_o[62:0], bus.ready_o}, 64'd0);
        rst = 1'b0;
        bus.opdata1_i = 32'd50;
        bus.opdata2_i = 32'd5;
        bus.signed_div_i = 1'b0;
        wait_ready(lat);
        lit("rst_restart_latency", 64'(lat), 64'd32);
        lit("rst_restart_result", bus.result_o, 64'h00000000_0000000A);
        bus.start_i = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; all values below assume 32.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port start_i, input, 1 bit: EX requests a divide; held high until the result is consumed.
REQ-005 The block SHALL have port annul_i, input, 1 bit: flush request; cancels any pending or running divide.
REQ-006 The block SHALL have port signed_div_i, input, 1 bit: 1 = two's-complement divide, 0 = unsigned divide.
REQ-007 The block SHALL have port opdata1_i, input, 32 bits: dividend.
REQ-008 The block SHALL have port opdata2_i, input, 32 bits: divisor.
REQ-009 The block SHALL have port result_o, output, 64 bits: [63:32] remainder (to HI), [31:0] quotient (to LO).
REQ-010 The block SHALL have port ready_o, output, 1 bit: result_o is valid.

Function
REQ-011 The block SHALL implement a four-state FSM with states FREE, BYZERO, ON and END.
REQ-012 FREE, start_i=1 and annul_i=0, divisor=0: the FSM SHALL go to BYZERO.
REQ-013 FREE, start_i=1 and annul_i=0, divisor≠0: the FSM SHALL latch the operands, go to ON and clear the 6-bit step counter.
- When signed_div_i=1, each negative operand SHALL be latched as its two's-complement magnitude.
- signed_div_i and both operand signs SHALL also be latched.
REQ-014 FREE, any other input combination: the FSM SHALL stay in FREE.
REQ-015 Operand, sign or mode changes after latching SHALL have no effect until the FSM returns to FREE.
REQ-016 ON: each clock the block SHALL perform one restoring shift-subtract step on a 65-bit {partial remainder, quotient} register and increment the counter.
- If the trial difference is non-negative, the step SHALL keep it and shift in 1.
- Otherwise the step SHALL restore and shift in 0.
REQ-017 ON: the step taken with counter=31 SHALL move the FSM to END and register the sign-corrected result in the same edge.
- Quotient SHALL be negated when signed and the operand signs differ.
- Remainder SHALL be negated when signed and the dividend is negative.
REQ-018 ON with annul_i=1 or start_i=0: the FSM SHALL go to FREE, discard the partial result and keep ready_o low.
REQ-019 BYZERO: the FSM SHALL go to END with result_o=0, or to FREE if annul_i=1 or start_i=0.
REQ-020 END: ready_o SHALL be 1 and result_o SHALL hold the final value.
REQ-021 END: the FSM SHALL stay in END while start_i=1, and go to FREE on the first cycle with start_i=0.
- ready_o and result_o SHALL be 0 in the cycle after leaving END.
REQ-022 END with annul_i=1: the FSM SHALL go to FREE.
REQ-023 Latency, start_i sampled at edge k with divisor≠0: ready_o SHALL first be 1 after edge k+32.
REQ-024 Latency, start_i sampled at edge k with divisor=0: ready_o SHALL first be 1 after edge k+1.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL wrap: quotient 0x80000000, remainder 0, with no exception.
REQ-026 If annul_i and start_i are both 1 in the same cycle, annul_i SHALL take priority in every state.
REQ-027 A new divide SHALL be accepted only from FREE, so back-to-back requests need at least one start_i=0 cycle between them.
REQ-028 ready_o SHALL be 0 in FREE, BYZERO and ON.
REQ-029 result_o SHALL be 0 in FREE, BYZERO and ON.

Reset
REQ-030 rst=1 at a rising edge SHALL force state FREE, counter 0, ready_o=0 and result_o=0, overriding all other inputs, including mid-ON.
REQ-031 In the first cycle after rst deasserts, the block SHALL accept start_i.

Verification
REQ-032 Unsigned 100 / 7: ready_o rises after edge k+32, result_o=0x00000002_0000000E.
REQ-033 Signed -7 / 2: result_o=0xFFFFFFFF_FFFFFFFD, i.e. remainder -1 and quotient -3.
REQ-034 Divide by zero, 5 / 0: ready_o rises after edge k+1, result_o=0. Lower start_i and the next cycle shows ready_o=0.
REQ-035 annul_i pulsed at step 10 of ON: FSM in FREE, ready_o never rises. A following 9 / 3 gives result_o=0x00000000_00000003.
REQ-036 Signed 0x80000000 / 0xFFFFFFFF: result_o=0x00000000_80000000.
REQ-037 rst asserted at step 20 of ON: ready_o=0 and result_o=0 after that edge. A new request then completes in 32 edges.
